// File: rtl/shift_deserializer_lsb.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready holding register.
// Define PARITY_CHECK_EN to receive W data bits plus one even-parity bit per frame.
module shift_deserializer_lsb #(
  parameter  int Word_Length = 8,
  localparam int CNT_W       = $clog2(Word_Length + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_rst,
  input  logic                   serial_in,
  input  logic                   serial_valid,
  output logic                   serial_ready,
  output logic [Word_Length-1:0] Data_Output,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [CNT_W-1:0]       bit_count,
  output logic                   parity_err
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(Word_Length);
`ifdef PARITY_CHECK_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Word_Length);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Word_Length - 1);
`endif

  state_t                 state_q, state_d;
  logic [Word_Length-1:0] shreg_q, shreg_d;
  logic [Word_Length-1:0] dout_q, dout_d;
  logic                   dvld_q, dvld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [Word_Length-1:0] shift_w, word_w;
  logic                   accept, drain;

  assign shift_w = {serial_in, shreg_q[Word_Length-1:1]};

`ifdef PARITY_CHECK_EN
  // The parity bit never enters shreg; the data word is already complete.
  logic perr_q, perr_d, hpar_q, hpar_d, wpar;
  assign word_w     = shreg_q;
  assign wpar       = ^{shreg_q, serial_in};
  assign parity_err = perr_q;
`else
  assign word_w     = shift_w;
  assign parity_err = 1'b0;
`endif

  assign serial_ready = (state_q == COLLECT);
  assign accept       = serial_valid && serial_ready;
  assign drain        = dvld_q && data_ready;
  assign Data_Output  = dout_q;
  assign data_valid   = dvld_q;
  assign bit_count    = cnt_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    cnt_d   = cnt_q;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
    hpar_d  = hpar_q;
`endif
    if (drain) dvld_d = 1'b0;
    if (sync_rst) begin
      // Output side keeps its handshake; only the partial word is discarded.
      state_d = COLLECT;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            if (cnt_q == LAST) begin
              if (!dvld_q || drain) begin
                dout_d  = word_w;
                dvld_d  = 1'b1;
                shreg_d = '0;
                cnt_d   = '0;
`ifdef PARITY_CHECK_EN
                perr_d  = wpar;
`endif
              end else begin
                state_d = HOLD;
                shreg_d = word_w;
                cnt_d   = FULL;
`ifdef PARITY_CHECK_EN
                hpar_d  = wpar;
`endif
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q < FULL) shreg_d = shift_w;
            end
          end
        end
        HOLD: begin
          if (data_ready) begin
            state_d = COLLECT;
            dout_d  = shreg_q;
            dvld_d  = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
`ifdef PARITY_CHECK_EN
            perr_d  = hpar_q;
`endif
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      shreg_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
      hpar_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      cnt_q   <= cnt_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
      hpar_q  <= hpar_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_deserializer_lsb.sv
// Directed bench for shift_deserializer_lsb (W=8); follows PARITY_CHECK_EN for frame length.
module tb_shift_deserializer_lsb;

  logic       clk = 1'b0;
  logic       reset = 1'b0, sync_rst = 1'b0, serial_in = 1'b0, serial_valid = 1'b0;
  logic       data_ready = 1'b0;
  logic       serial_ready, data_valid, parity_err;
  logic [7:0] Data_Output;
  logic [3:0] bit_count;

  int checks = 0, failures = 0;
  logic sr_drop;

  shift_deserializer_lsb #(.Word_Length(8)) dut (
    .clk(clk), .reset(reset), .sync_rst(sync_rst),
    .serial_in(serial_in), .serial_valid(serial_valid), .serial_ready(serial_ready),
    .Data_Output(Data_Output), .data_valid(data_valid), .data_ready(data_ready),
    .bit_count(bit_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // tx lists bits in transmission order, leftmost sent first; exp is the hand-assembled word.
  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] tx, input logic rdy_last, input logic bad_par);
    int n;
    n = 8;
`ifdef PARITY_CHECK_EN
    n = 9;
`endif
    for (int i = 0; i < n; i++) begin
      serial_valid = 1'b1;
      serial_in    = (i < 8) ? tx[7-i] : ((^tx) ^ bad_par);
      if (i == n - 1) data_ready = rdy_last;
      tick();
      if (i < n - 1 && !serial_ready) sr_drop = 1'b1;
    end
    serial_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'b10100101, 8'hA5};
    vecs[1] = '{8'b10000000, 8'h01};
    vecs[2] = '{8'b00010011, 8'hC8};
    vecs[3] = '{8'b01001000, 8'h12};
    vecs[4] = '{8'b11111111, 8'hFF};
    vecs[5] = '{8'b00000000, 8'h00};
    vecs[6] = '{8'b00000111, 8'hE0};

    // Reset
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_dout", Data_Output, 8'h00);
    chk("rst_dvld", data_valid, 1'b0);
    chk("rst_srdy", serial_ready, 1'b1);
    chk("rst_cnt", bit_count, 4'd0);
    chk("rst_perr", parity_err, 1'b0);
    reset = 1'b0;

    // Single word 0xA5, one-cycle valid pulse
    data_ready = 1'b1;
    send_frame(8'b10100101, 1'b1, 1'b0);
    chk("a5_dout", Data_Output, 8'hA5);
    chk("a5_dvld", data_valid, 1'b1);
    chk("a5_cnt", bit_count, 4'd0);
    chk("a5_perr", parity_err, 1'b0);
    tick();
    chk("a5_drain", data_valid, 1'b0);

    // Back-to-back table words with data_ready held high
    sr_drop = 1'b0;
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].tx, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_dout", k), Data_Output, vecs[k].exp);
      chk($sformatf("tbl%0d_dvld", k), data_valid, 1'b1);
      chk($sformatf("tbl%0d_cnt", k), bit_count, 4'd0);
    end
    chk("tbl_srdy_steady", sr_drop, 1'b0);
    tick();
    chk("tbl_drain", data_valid, 1'b0);

    // Stall into HOLD, then release
    data_ready = 1'b0;
    send_frame(rev(8'h3C), 1'b0, 1'b0);
    chk("h_first_dout", Data_Output, 8'h3C);
    send_frame(rev(8'hFF), 1'b0, 1'b0);
    chk("h_srdy", serial_ready, 1'b0);
    chk("h_cnt", bit_count, 4'd8);
    chk("h_dout", Data_Output, 8'h3C);
    serial_valid = 1'b1; serial_in = 1'b0;
    repeat (2) tick();
    serial_valid = 1'b0;
    chk("h_ignore_cnt", bit_count, 4'd8);
    chk("h_ignore_dout", Data_Output, 8'h3C);
    chk("h_ignore_dvld", data_valid, 1'b1);
    data_ready = 1'b1;
    tick();
    chk("h_rel_dout", Data_Output, 8'hFF);
    chk("h_rel_dvld", data_valid, 1'b1);
    chk("h_rel_srdy", serial_ready, 1'b1);
    chk("h_rel_cnt", bit_count, 4'd0);
    tick();
    chk("h_rel_drain", data_valid, 1'b0);

    // sync_rst drops a partial word but leaves the output alone
    data_ready = 1'b0;
    send_frame(rev(8'h3C), 1'b0, 1'b0);
    serial_valid = 1'b1; serial_in = 1'b1;
    repeat (3) tick();
    chk("sr_cnt3", bit_count, 4'd3);
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0; serial_valid = 1'b0;
    chk("sr_cnt0", bit_count, 4'd0);
    chk("sr_dout", Data_Output, 8'h3C);
    chk("sr_dvld", data_valid, 1'b1);
    data_ready = 1'b1;
    send_frame(rev(8'h81), 1'b1, 1'b0);
    chk("sr_81", Data_Output, 8'h81);
    chk("sr_81_dvld", data_valid, 1'b1);

    // Drain in the same cycle as the last bit: no HOLD
    data_ready = 1'b0;
    sr_drop = 1'b0;
    send_frame(rev(8'h5A), 1'b1, 1'b0);
    chk("sd_dout", Data_Output, 8'h5A);
    chk("sd_dvld", data_valid, 1'b1);
    chk("sd_srdy", serial_ready, 1'b1);
    chk("sd_nodrop", sr_drop, 1'b0);
    chk("sd_cnt", bit_count, 4'd0);

    // reset while in HOLD emits nothing
    data_ready = 1'b0;
    send_frame(rev(8'hC8), 1'b0, 1'b0);
    chk("rh_srdy0", serial_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rh_dvld", data_valid, 1'b0);
    chk("rh_dout", Data_Output, 8'h00);
    chk("rh_srdy", serial_ready, 1'b1);
    chk("rh_cnt", bit_count, 4'd0);
    data_ready = 1'b1;
    repeat (2) tick();
    chk("rh_nowrd", data_valid, 1'b0);

    // reset mid-word
    serial_valid = 1'b1; serial_in = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; serial_valid = 1'b0;
    chk("rw_cnt", bit_count, 4'd0);
    chk("rw_dvld", data_valid, 1'b0);

`ifdef PARITY_CHECK_EN
    // Parity: good then bad parity bit on 0xA5
    data_ready = 1'b1;
    send_frame(8'b10100101, 1'b1, 1'b0);
    chk("par_ok_dout", Data_Output, 8'hA5);
    chk("par_ok", parity_err, 1'b0);
    send_frame(8'b10100101, 1'b1, 1'b1);
    chk("par_bad_dout", Data_Output, 8'hA5);
    chk("par_bad", parity_err, 1'b1);
`else
    chk("nopar_tied", parity_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
